// File: rtl/dmtd_phase_meter.sv
// Measures beat_a->beat_b phase and beat_a period in clk cycles from two DMTD beat signals.
// Latency: 2+DEGLITCH cycles from raw edge to FSM; result held in HOLD until out_valid&&out_ready.

module dmtd_beat_filter #(
  parameter int DEGLITCH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beat_i,
  output logic rise_o
);
  localparam logic [3:0] DG_LAST = 4'(DEGLITCH - 1);

  logic [1:0] sync_q;
  logic       lvl_q, lvl_d;
  logic [3:0] dg_q, dg_d;

  always_comb begin
    lvl_d = lvl_q;
    dg_d  = '0;
    // Run length of synchronized samples disagreeing with the filtered level.
    if (sync_q[1] != lvl_q) begin
      if (dg_q == DG_LAST) begin
        lvl_d = sync_q[1];
      end else begin
        dg_d = dg_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      dg_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], beat_i};
      lvl_q  <= lvl_d;
      dg_q   <= dg_d;
    end
  end

  assign rise_o = lvl_d & ~lvl_q;
endmodule

module dmtd_phase_meter #(
  parameter int CNT_W    = 16,
  parameter int DEGLITCH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_a,
  input  logic             beat_b,
  input  logic             meas_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             overflow
);
  typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, WAIT_A2, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             fa_rise, fb_rise;

  dmtd_beat_filter #(.DEGLITCH(DEGLITCH)) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .beat_i (beat_a),
    .rise_o (fa_rise)
  );

  dmtd_beat_filter #(.DEGLITCH(DEGLITCH)) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .beat_i (beat_b),
    .rise_o (fb_rise)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (meas_en) state_d = WAIT_A;
      end
      WAIT_A: begin
        if (!meas_en) begin
          state_d = IDLE;
        end else if (fa_rise) begin
          cnt_d = '0;
          if (fb_rise) begin
            phase_d = '0;
            state_d = WAIT_A2;
          end else begin
            state_d = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        // Saturation is checked first so a latched field can never wrap.
        if (!meas_en) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          phase_d  = CNT_MAX;
          period_d = CNT_MAX;
          ovf_d    = 1'b1;
          state_d  = HOLD;
        end else if (fb_rise) begin
          phase_d = cnt_q + CNT_ONE;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = WAIT_A2;
        end else if (fa_rise) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_A2: begin
        if (!meas_en) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          period_d = CNT_MAX;
          ovf_d    = 1'b1;
          state_d  = HOLD;
        end else if (fa_rise) begin
          period_d = cnt_q + CNT_ONE;
          ovf_d    = 1'b0;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (out_ready) state_d = meas_en ? WAIT_A : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phase_q  <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign phase_cnt  = phase_q;
  assign period_cnt = period_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_dmtd_phase_meter.sv
// Directed bench for dmtd_phase_meter: expected results queued at stimulus time, checked on out_valid.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_dmtd_phase_meter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        beat_a = 1'b0;
  logic        beat_b = 1'b0;
  logic        meas_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] phase_cnt;
  logic [15:0] period_cnt;
  logic        overflow;

  typedef struct {
    logic [15:0] ph;
    logic [15:0] per;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   errors = 0;
  int   checks = 0;

  dmtd_phase_meter #(.CNT_W(16), .DEGLITCH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_a     (beat_a),
    .beat_b     (beat_b),
    .meas_en    (meas_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .phase_cnt  (phase_cnt),
    .period_cnt (period_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input exp_t e);
    chk({tag, ".valid"},  32'(out_valid),  32'(v));
    chk({tag, ".phase"},  32'(phase_cnt),  32'(e.ph));
    chk({tag, ".period"}, 32'(period_cnt), 32'(e.per));
    chk({tag, ".ovf"},    32'(overflow),   32'(e.ovf));
  endtask

  // One measurement from WAIT_A with both filtered beats low; leaves both beats low.
  task automatic meas(input int ph, input int per);
    exp_t e;
    beat_a = 1'b1;
    if (ph == 0) beat_b = 1'b1;
    if (ph > 0) begin
      cyc(ph);
      beat_b = 1'b1;
    end
    cyc(per - 20 - ph);
    beat_a = 1'b0;
    cyc(20);
    beat_a = 1'b1;
    e.ph = 16'(ph); e.per = 16'(per); e.ovf = 1'b0;
    sb.push_back(e);
    cyc(10);
    beat_a = 1'b0;
    beat_b = 1'b0;
    cyc(10);
  endtask

  task automatic wait_result(input string tag, input int budget, output exp_t e);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin e.ph = '0; e.per = '0; e.ovf = 1'b0; end
    chk_outs(tag, 1'b1, e);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk({tag, ".valid_fall"}, 32'(out_valid), 32'd0);
  endtask

  task automatic expect_no_valid(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({tag, ".no_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    exp_t e;
    exp_t zero;
    zero.ph = '0; zero.per = '0; zero.ovf = 1'b0;

    cyc(3);
    chk_outs("reset", 1'b0, zero);
    rst_n = 1'b1;
    meas_en = 1'b1;
    cyc(10);

    // Basic phase/period measurement.
    meas(100, 1000);
    wait_result("basic", 100, e);
    handshake("basic");

    // Coincident edges give zero phase.
    meas(0, 500);
    wait_result("coincident", 100, e);
    handshake("coincident");

    // A short glitch on beat_b before the real edge must not be measured.
    beat_a = 1'b1;
    cyc(40);
    beat_b = 1'b1;
    cyc(3);
    beat_b = 1'b0;
    cyc(57);
    beat_b = 1'b1;
    cyc(600 - 20 - 100);
    beat_a = 1'b0;
    cyc(20);
    beat_a = 1'b1;
    e.ph = 16'd100; e.per = 16'd600; e.ovf = 1'b0;
    sb.push_back(e);
    cyc(10);
    beat_a = 1'b0;
    beat_b = 1'b0;
    cyc(10);
    wait_result("glitch", 100, e);
    handshake("glitch");

    // Missing beat_b edge saturates both fields.
    beat_a = 1'b1;
    e.ph = 16'hFFFF; e.per = 16'hFFFF; e.ovf = 1'b1;
    sb.push_back(e);
    wait_result("saturate", 70000, e);
    beat_a = 1'b0;
    cyc(10);
    handshake("saturate");

    // Backpressure: result stays frozen while beats toggle in HOLD.
    meas(60, 400);
    wait_result("hold", 100, held);
    for (int k = 0; k < 5; k++) begin
      beat_a = 1'b1;
      beat_b = 1'b1;
      cyc(5);
      beat_a = 1'b0;
      beat_b = 1'b0;
      cyc(5);
      chk_outs($sformatf("hold_stable%0d", k), 1'b1, held);
    end
    cyc(10);
    handshake("hold");
    meas(200, 800);
    wait_result("after_hold", 100, e);
    handshake("after_hold");

    // Reset in WAIT_A2 discards the measurement and clears outputs.
    beat_a = 1'b1;
    cyc(50);
    beat_b = 1'b1;
    cyc(50);
    rst_n = 1'b0;
    beat_a = 1'b0;
    beat_b = 1'b0;
    cyc(2);
    chk_outs("mid_reset", 1'b0, zero);
    rst_n = 1'b1;
    expect_no_valid("post_reset", 30);

    // Dropping meas_en in WAIT_B aborts without output.
    beat_a = 1'b1;
    cyc(30);
    meas_en = 1'b0;
    cyc(5);
    beat_b = 1'b1;
    expect_no_valid("abort", 40);
    chk_outs("abort", 1'b0, zero);
    beat_a = 1'b0;
    beat_b = 1'b0;
    cyc(10);
    meas_en = 1'b1;
    cyc(5);
    meas(37, 300);
    wait_result("recover", 100, e);
    handshake("recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
